// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Transmit-side byte FIFO for the UART. Bytes written by the APB register
//   block are queued here and handed to the transmitter, which pops them with
//   an active-low read strobe. Single clock domain.
//
//   Optional feature macro: UART_TX_FIFO_AFULL_EN
//     defined   -> fifo_afull is a registered (fifo_count >= AFULL_LEVEL),
//                  lagging fifo_count by one clock.
//     undefined -> fifo_afull is tied low and no threshold logic is built.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   flush        in   synchronous clear, active high, highest priority
//   wr_en        in   write strobe, one byte per cycle
//   wr_data      in   byte to enqueue
//   fifo_read_n  in   read strobe from transmitter, active low
//   fifo_dout    out  registered head byte, valid the cycle after a read
//   fifo_empty   out  no entries stored
//   fifo_full    out  DEPTH entries stored
//   fifo_count   out  occupancy 0..DEPTH
//   overflow     out  sticky: a write was dropped
//   fifo_afull   out  almost-full (see macro above)
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH_LOG2  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  fifo_read_n,
  output logic [WIDTH-1:0]      fifo_dout,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic                  fifo_afull
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull_level
    $error("uart_tx_fifo: AFULL_LEVEL must be in 1..DEPTH");
  end

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic [WIDTH-1:0]      dout_q;
  logic                  ovf_q;
  logic                  rd_acc;
  logic                  wr_acc;

  // Flags decode only the registered count: no path from the strobes.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_count = count_q;
  assign fifo_dout  = dout_q;
  assign overflow   = ovf_q;

  // A read on empty is ignored; a full FIFO still takes a write when the
  // same cycle frees an entry.
  assign rd_acc = !fifo_read_n && !fifo_empty;
  assign wr_acc = wr_en && (!fifo_full || rd_acc);

  always_comb begin
    count_nxt = count_q;
    if (wr_acc && !rd_acc) begin
      count_nxt = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count_q - 1'b1;
    end
  end

  // Storage: not reset, and a write coincident with flush is discarded.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Control and output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        dout_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !wr_acc) begin
        ovf_q <= 1'b1;
      end
    end
  end

`ifdef UART_TX_FIFO_AFULL_EN
  localparam logic [DEPTH_LOG2:0] AFULL_CNT = (DEPTH_LOG2 + 1)'(AFULL_LEVEL);
  logic afull_q;

  // Samples the registered count, so it follows fifo_count one clock later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      afull_q <= 1'b0;
    end else if (flush) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= (count_q >= AFULL_CNT);
    end
  end

  assign fifo_afull = afull_q;
`else
  assign fifo_afull = 1'b0;
`endif

endmodule
